// File: rtl/spike_binner.sv
// spike_binner: counts active spike lines per sample and accumulates them over
// a programmable bin of enabled samples. At each bin end the total is presented
// on spike_cnt_out with a single-cycle cnt_valid strobe.
// Optional build macro SPIKE_BINNER_SAT_EN: saturating accumulation plus a
// sat_flag output; when undefined the accumulator wraps modulo 2^CNT_W.
module spike_binner #(
  parameter int NN    = 16,
  parameter int CNT_W = 32,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [NN-1:0]    spike_in,
  input  logic [WIN_W-1:0] bin_len,
  output logic [CNT_W-1:0] spike_cnt_out,
  output logic             cnt_valid,
  output logic             busy
`ifdef SPIKE_BINNER_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  localparam int PC_W = $clog2(NN + 1);

  typedef enum logic {IDLE, RUN} state_t;

  // Number of set bits in one sample.
  function automatic logic [PC_W-1:0] popcount(input logic [NN-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NN; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

`ifdef SPIKE_BINNER_SAT_EN
  // True when a + b does not fit in CNT_W bits.
  function automatic logic acc_ovf(input logic [CNT_W-1:0] a, input logic [PC_W-1:0] b);
    logic [CNT_W:0] full;
    full = {1'b0, a} + (CNT_W + 1)'(b);
    return full[CNT_W];
  endfunction
`endif

  // Accumulator add: saturating when the option is built in, wrapping otherwise.
  function automatic logic [CNT_W-1:0] acc_add(input logic [CNT_W-1:0] a, input logic [PC_W-1:0] b);
`ifdef SPIKE_BINNER_SAT_EN
    if (acc_ovf(a, b)) begin
      return '1;
    end
`endif
    return a + CNT_W'(b);
  endfunction

  state_t           state, state_nx;
  logic [PC_W-1:0]  pc_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] acc;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] len_act;

  logic [WIN_W-1:0] len_eff;
  logic [WIN_W-1:0] cur_len;
  logic [WIN_W-1:0] cur_idx;
  logic [CNT_W-1:0] acc_base;
  logic [CNT_W-1:0] sum;
  logic             bin_last;
`ifdef SPIKE_BINNER_SAT_EN
  logic             sum_sat;
`endif

  // ---- stage 1: per-sample popcount, qualified by enable ----
  // Register the masked popcount and its valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      pc_p1  <= popcount(spike_in & {NN{enable}});
      vld_p1 <= enable;
    end
  end

  // ---- stage 2: bin accumulation and FSM ----
  // In IDLE the incoming sample is treated as sample 0 of a fresh bin whose
  // length is taken from bin_len right now; in RUN the latched length is used.
  always_comb begin
    len_eff  = (bin_len == '0) ? WIN_W'(1) : bin_len;
    acc_base = (state == IDLE) ? '0 : acc;
    cur_len  = (state == IDLE) ? len_eff : len_act;
    cur_idx  = (state == IDLE) ? '0 : win_cnt;
    sum      = acc_add(acc_base, pc_p1);
`ifdef SPIKE_BINNER_SAT_EN
    sum_sat  = acc_ovf(acc_base, pc_p1);
`endif
    bin_last = vld_p1 && (cur_idx == (cur_len - WIN_W'(1)));
    state_nx = state;
    if (state == IDLE) begin
      if (vld_p1 && !bin_last) begin
        state_nx = RUN;
      end
    end else begin
      if (bin_last) begin
        state_nx = IDLE;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Accumulator, sample index, latched bin length and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc           <= '0;
      win_cnt       <= '0;
      len_act       <= '0;
      spike_cnt_out <= '0;
      cnt_valid     <= 1'b0;
    end else begin
      cnt_valid <= 1'b0;
      if (vld_p1) begin
        if (state == IDLE) begin
          len_act <= len_eff;
        end
        if (bin_last) begin
          spike_cnt_out <= sum;
          cnt_valid     <= 1'b1;
          acc           <= '0;
          win_cnt       <= '0;
        end else begin
          acc     <= sum;
          win_cnt <= cur_idx + WIN_W'(1);
        end
      end
    end
  end

`ifdef SPIKE_BINNER_SAT_EN
  // Sticky saturation indicator: restarts with each bin, so at cnt_valid it
  // reflects exactly the bin being reported.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= 1'b0;
    end else if (vld_p1) begin
      sat_flag <= ((state == IDLE) ? 1'b0 : sat_flag) | sum_sat;
    end
  end
`endif

  assign busy = (state == RUN);

endmodule

// File: tb/tb_spike_binner.sv
// Bench for spike_binner: a 32-bit and an 8-bit accumulator instance share the
// stimulus. A behavioural bin model pushes per-cycle expectations into a queue
// when each sample is driven; a negedge monitor pops them two edges later.
// Case table plus hand-written sequences for bin_len change and async reset.
`timescale 1ns/1ps
module tb_spike_binner;
  localparam int NN    = 16;
  localparam int WIN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [NN-1:0]    spike_in = '0;
  logic [WIN_W-1:0] bin_len = '0;
  logic [31:0]      cnt32;
  logic             v32, b32;
  logic [7:0]       cnt8;
  logic             v8, b8;
`ifdef SPIKE_BINNER_SAT_EN
  logic             s32, s8;
`endif

  spike_binner #(.NN(NN), .CNT_W(32), .WIN_W(WIN_W)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in), .bin_len(bin_len),
    .spike_cnt_out(cnt32), .cnt_valid(v32), .busy(b32)
`ifdef SPIKE_BINNER_SAT_EN
    , .sat_flag(s32)
`endif
  );

  spike_binner #(.NN(NN), .CNT_W(8), .WIN_W(WIN_W)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in), .bin_len(bin_len),
    .spike_cnt_out(cnt8), .cnt_valid(v8), .busy(b8)
`ifdef SPIKE_BINNER_SAT_EN
    , .sat_flag(s8)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    int          due;
    logic        v;
    logic [31:0] c32;
    logic [7:0]  c8;
    logic        b;
    logic        s8;
  } exp_t;

  exp_t sbq[$];

  // Behavioural bin model state
  bit     m_run = 0;
  int     m_len = 0;
  int     m_n = 0;
  longint m_acc = 0;
  longint m_out = 0;

  bit mon_en = 0;
  int pulses = 0;
  longint first32 = -1;

  task automatic model_clear();
    m_run = 0; m_len = 0; m_n = 0; m_acc = 0; m_out = 0;
    pulses = 0; first32 = -1;
  endtask

  // Drive one sample after a rising edge and push what the outputs must show
  // two edges later.
  task automatic step(input logic en, input logic [15:0] spk, input int blen);
    exp_t e;
    @(posedge clk);
    #1;
    enable = en; spike_in = spk; bin_len = blen[15:0];
    e.v = 1'b0;
    if (en) begin
      if (!m_run) begin
        m_len = (blen == 0) ? 1 : blen;
        m_acc = 0;
        m_n = 0;
      end
      m_acc += $countones(spk);
      m_n++;
      if (m_n == m_len) begin
        m_out = m_acc;
        e.v = 1'b1;
        m_run = 0;
      end else begin
        m_run = 1;
      end
    end
    e.due = cyc + 2;
    e.b   = m_run;
    e.c32 = 32'(m_out);
`ifdef SPIKE_BINNER_SAT_EN
    e.c8  = (m_out > 255) ? 8'hFF : 8'(m_out);
`else
    e.c8  = 8'(m_out);
`endif
    e.s8  = (m_out > 255);
    sbq.push_back(e);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk("sb_stale", 64'(e.due), 64'(cyc));
        chk("valid32", v32, e.v);
        chk("valid8", v8, e.v);
        chk("busy32", b32, e.b);
        chk("busy8", b8, e.b);
        chk("cnt32", cnt32, e.c32);
        chk("cnt8", cnt8, e.c8);
`ifdef SPIKE_BINNER_SAT_EN
        if (e.v) begin
          chk("sat32", s32, 1'b0);
          chk("sat8", s8, e.s8);
        end
`endif
      end
      if (v32) begin
        if (pulses == 0) first32 = cnt32;
        pulses++;
      end
    end
  end

  // Assert reset away from the edge, check outputs clear at once, release.
  task automatic do_reset();
    mon_en = 0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    enable = 1'b0;
    #1;
    chk("rst_cnt32", cnt32, 32'd0);
    chk("rst_cnt8", cnt8, 8'd0);
    chk("rst_valid", {v32, v8}, 2'b00);
    chk("rst_busy", {b32, b8}, 2'b00);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    sbq.delete();
    model_clear();
    mon_en = 1;
  endtask

  task automatic drain(input int blen);
    repeat (3) step(1'b0, 16'h0000, blen);
  endtask

  typedef struct {
    int          blen;
    logic [15:0] spk;
    int          n;
    bit          alt;
    int          exp_bins;
    longint      exp32;
    int          exp8;
    bit          exp_sat;
  } case_t;

  case_t cases[4];

  initial begin
    cases[0] = '{blen: 4,  spk: 16'hFFFF, n: 4,  alt: 1'b0, exp_bins: 1, exp32: 64,  exp8: 64, exp_sat: 1'b0};
    cases[1] = '{blen: 0,  spk: 16'h0005, n: 6,  alt: 1'b0, exp_bins: 6, exp32: 2,   exp8: 2,  exp_sat: 1'b0};
    cases[2] = '{blen: 5,  spk: 16'h00FF, n: 10, alt: 1'b1, exp_bins: 1, exp32: 40,  exp8: 40, exp_sat: 1'b0};
`ifdef SPIKE_BINNER_SAT_EN
    cases[3] = '{blen: 20, spk: 16'hFFFF, n: 20, alt: 1'b0, exp_bins: 1, exp32: 320, exp8: 255, exp_sat: 1'b1};
`else
    cases[3] = '{blen: 20, spk: 16'hFFFF, n: 20, alt: 1'b0, exp_bins: 1, exp32: 320, exp8: 64, exp_sat: 1'b0};
`endif

    for (int c = 0; c < 4; c++) begin
      do_reset();
      for (int i = 0; i < cases[c].n; i++) begin
        step(cases[c].alt ? logic'(i % 2 == 0) : 1'b1, cases[c].spk, cases[c].blen);
      end
      drain(cases[c].blen);
      chk($sformatf("case%0d_bins", c), 64'(pulses), 64'(cases[c].exp_bins));
      chk($sformatf("case%0d_cnt32", c), cnt32, 64'(cases[c].exp32));
      chk($sformatf("case%0d_cnt8", c), cnt8, 64'(cases[c].exp8));
`ifdef SPIKE_BINNER_SAT_EN
      chk($sformatf("case%0d_sat8", c), s8, cases[c].exp_sat);
`endif
    end

    // bin_len=3, ramp then steady 0x000F: bins of 6, 12, 12 back to back
    do_reset();
    step(1'b1, 16'h0001, 3);
    step(1'b1, 16'h0003, 3);
    step(1'b1, 16'h0007, 3);
    repeat (6) step(1'b1, 16'h000F, 3);
    drain(3);
    chk("ramp_bins", 64'(pulses), 64'd3);
    chk("ramp_first", 64'(first32), 64'd6);
    chk("ramp_last", cnt32, 32'd12);

    // bin_len 4 -> 2 after the second sample: current bin stays 4 long
    do_reset();
    repeat (2) step(1'b1, 16'h0001, 4);
    repeat (6) step(1'b1, 16'h0001, 2);
    drain(2);
    chk("blchg_bins", 64'(pulses), 64'd3);
    chk("blchg_first", 64'(first32), 64'd4);
    chk("blchg_last", cnt32, 32'd2);

    // Reset in the middle of a bin after a completed one
    do_reset();
    repeat (6) step(1'b1, 16'hFFFF, 4);
    step(1'b0, 16'h0000, 4);
    #1;
    chk("pre_rst_busy", b32, 1'b1);
    chk("pre_rst_cnt", cnt32, 32'd64);
    do_reset();
    repeat (4) step(1'b1, 16'h0001, 4);
    drain(4);
    chk("post_rst_bins", 64'(pulses), 64'd1);
    chk("post_rst_cnt", cnt32, 32'd4);

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
